// File: rtl/branch_decode_unit_if.sv
// Fetch-side and execute-side handshake signals of the branch/decode stage.
// The slave modport is the decode unit itself; master is the surrounding pipeline.
interface branch_decode_unit_if;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        pc_source;
   logic [31:0] branch_target;
   logic        ex_valid;
   logic        ex_ready;
   logic [1:0]  ex_op;
   logic [31:0] ex_a;
   logic [31:0] ex_imm;
   logic [4:0]  ex_dst;

   modport master (
      output instr_valid, instr, instr_pc, ex_ready,
      input  instr_ready, pc_source, branch_target,
      input  ex_valid, ex_op, ex_a, ex_imm, ex_dst
   );

   modport slave (
      input  instr_valid, instr, instr_pc, ex_ready,
      output instr_ready, pc_source, branch_target,
      output ex_valid, ex_op, ex_a, ex_imm, ex_dst
   );
endinterface

// File: rtl/branch_decode_unit.sv
// Decode/branch-resolve stage: latches an instruction, reads rs/rt, resolves branches and
// jumps back into fetch, and hands arithmetic ops to execute over a valid/ready handshake.
module branch_decode_unit #(
   parameter int SQUASH_SLOTS = 1,
   parameter int LINK_REG     = 31
) (
   input  logic                 clock,
   input  logic                 reset,
   branch_decode_unit_if.slave  bus,
   output logic [4:0]           rf_rs_addr,
   output logic [4:0]           rf_rt_addr,
   input  logic [31:0]          rf_rs_data,
   input  logic [31:0]          rf_rt_data,
   output logic                 link_we,
   output logic [4:0]           link_addr,
   output logic [31:0]          link_data,
   output logic                 illegal
);
   typedef enum logic [2:0] {IDLE, READ, EVAL, ISSUE, REDIRECT} state_t;

   localparam logic [5:0] OP_BEQ  = 6'h08;
   localparam logic [5:0] OP_BNE  = 6'h09;
   localparam logic [5:0] OP_BGT  = 6'h0A;
   localparam logic [5:0] OP_BGE  = 6'h0B;
   localparam logic [5:0] OP_BLT  = 6'h0C;
   localparam logic [5:0] OP_BLE  = 6'h0D;
   localparam logic [5:0] OP_J    = 6'h0E;
   localparam logic [5:0] OP_IMUL = 6'h0F;
   localparam logic [5:0] OP_DIVI = 6'h10;
   localparam logic [5:0] OP_JAL  = 6'h11;
   localparam logic [5:0] OP_SRA  = 6'h12;

   state_t      state_reg;
   logic [2:0]  squash_cnt_reg;
   logic [31:0] ir_reg;
   logic [31:0] pc_reg;

   logic        instr_ready_reg;
   logic        pc_source_reg;
   logic [31:0] branch_target_reg;
   logic        ex_valid_reg;
   logic [1:0]  ex_op_reg;
   logic [31:0] ex_a_reg;
   logic [31:0] ex_imm_reg;
   logic [4:0]  ex_dst_reg;
   logic        link_we_reg;
   logic [4:0]  link_addr_reg;
   logic [31:0] link_data_reg;
   logic        illegal_reg;
   logic [4:0]  rf_rs_addr_reg;
   logic [4:0]  rf_rt_addr_reg;

   logic [5:0]  opcode;
   logic [31:0] imm_sext;
   logic [31:0] br_target;
   logic [31:0] jump_target;
   logic [5:0]  cmp_vec;
   logic [5:0]  br_hit;
   logic        branch_taken;

   assign opcode      = ir_reg[31:26];
   assign imm_sext    = {{16{ir_reg[15]}}, ir_reg[15:0]};
   assign br_target   = pc_reg + imm_sext;
   assign jump_target = {pc_reg[31:26], ir_reg[25:0]};

   // Bit i holds the condition of branch opcode OP_BEQ+i (beq, bne, bgt, bge, blt, ble).
   assign cmp_vec = {
      $signed(rf_rs_data) <= $signed(rf_rt_data),
      $signed(rf_rs_data) <  $signed(rf_rt_data),
      $signed(rf_rs_data) >= $signed(rf_rt_data),
      $signed(rf_rs_data) >  $signed(rf_rt_data),
      rf_rs_data != rf_rt_data,
      rf_rs_data == rf_rt_data
   };

   generate
      for (genvar gi = 0; gi < 6; gi++) begin : g_br
         assign br_hit[gi] = (opcode == (OP_BEQ + 6'(gi))) && cmp_vec[gi];
      end
   endgenerate

   assign branch_taken = |br_hit;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg         <= IDLE;
         squash_cnt_reg    <= '0;
         ir_reg            <= '0;
         pc_reg            <= '0;
         instr_ready_reg   <= 1'b1;
         pc_source_reg     <= 1'b0;
         branch_target_reg <= '0;
         ex_valid_reg      <= 1'b0;
         ex_op_reg         <= '0;
         ex_a_reg          <= '0;
         ex_imm_reg        <= '0;
         ex_dst_reg        <= '0;
         link_we_reg       <= 1'b0;
         link_addr_reg     <= '0;
         link_data_reg     <= '0;
         illegal_reg       <= 1'b0;
         rf_rs_addr_reg    <= '0;
         rf_rt_addr_reg    <= '0;
      end else begin
         pc_source_reg <= 1'b0;
         link_we_reg   <= 1'b0;
         illegal_reg   <= 1'b0;

         case (state_reg)
            IDLE: begin
               // Wrong-path words after a redirect are consumed here, NOPs included.
               if (bus.instr_valid) begin
                  if (squash_cnt_reg != 3'd0) begin
                     squash_cnt_reg <= squash_cnt_reg - 3'd1;
                  end else if (bus.instr != 32'd0) begin
                     ir_reg          <= bus.instr;
                     pc_reg          <= bus.instr_pc;
                     rf_rs_addr_reg  <= bus.instr[25:21];
                     rf_rt_addr_reg  <= bus.instr[20:16];
                     instr_ready_reg <= 1'b0;
                     state_reg       <= READ;
                  end
               end
            end

            READ: state_reg <= EVAL;

            EVAL: begin
               branch_target_reg <= ((opcode == OP_J) || (opcode == OP_JAL)) ? jump_target : br_target;
               case (opcode)
                  OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE: begin
                     if (branch_taken) begin
                        pc_source_reg <= 1'b1;
                        state_reg     <= REDIRECT;
                     end else begin
                        instr_ready_reg <= 1'b1;
                        state_reg       <= IDLE;
                     end
                  end
                  OP_J: begin
                     pc_source_reg <= 1'b1;
                     state_reg     <= REDIRECT;
                  end
                  OP_JAL: begin
                     pc_source_reg <= 1'b1;
                     link_we_reg   <= 1'b1;
                     link_addr_reg <= 5'(LINK_REG);
                     link_data_reg <= pc_reg + 32'd1;
                     state_reg     <= REDIRECT;
                  end
                  OP_IMUL, OP_DIVI, OP_SRA: begin
                     ex_valid_reg <= 1'b1;
                     ex_op_reg    <= (opcode == OP_IMUL) ? 2'b00 :
                                     (opcode == OP_DIVI) ? 2'b01 : 2'b10;
                     ex_a_reg     <= rf_rs_data;
                     ex_imm_reg   <= imm_sext;
                     ex_dst_reg   <= ir_reg[20:16];
                     state_reg    <= ISSUE;
                  end
                  default: begin
                     // Opcode 0 with non-zero operand bits is treated as a harmless no-op.
                     illegal_reg     <= (opcode != 6'd0);
                     instr_ready_reg <= 1'b1;
                     state_reg       <= IDLE;
                  end
               endcase
            end

            ISSUE: begin
               if (bus.ex_ready) begin
                  ex_valid_reg    <= 1'b0;
                  instr_ready_reg <= 1'b1;
                  state_reg       <= IDLE;
               end
            end

            REDIRECT: begin
               squash_cnt_reg  <= 3'(SQUASH_SLOTS);
               instr_ready_reg <= 1'b1;
               state_reg       <= IDLE;
            end

            default: begin
               instr_ready_reg <= 1'b1;
               state_reg       <= IDLE;
            end
         endcase
      end
   end

   assign bus.instr_ready   = instr_ready_reg;
   assign bus.pc_source     = pc_source_reg;
   assign bus.branch_target = branch_target_reg;
   assign bus.ex_valid      = ex_valid_reg;
   assign bus.ex_op         = ex_op_reg;
   assign bus.ex_a          = ex_a_reg;
   assign bus.ex_imm        = ex_imm_reg;
   assign bus.ex_dst        = ex_dst_reg;
   assign link_we           = link_we_reg;
   assign link_addr         = link_addr_reg;
   assign link_data         = link_data_reg;
   assign illegal           = illegal_reg;
   assign rf_rs_addr        = rf_rs_addr_reg;
   assign rf_rt_addr        = rf_rt_addr_reg;
endmodule

// File: tb/tb_branch_decode_unit.sv
// Directed bench for branch_decode_unit: a per-instruction outcome model fills a timeline of
// expected outputs, a compare process checks it every cycle, and literals pin key results.
module tb_branch_decode_unit;
   localparam int SQ    = 1;
   localparam int DEPTH = 4096;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  rf_rs_addr, rf_rt_addr;
   logic [31:0] rf_rs_data, rf_rt_data;
   logic        link_we;
   logic [4:0]  link_addr;
   logic [31:0] link_data;
   logic        illegal;

   branch_decode_unit_if bus();

   branch_decode_unit #(.SQUASH_SLOTS(SQ), .LINK_REG(31)) dut (
      .clock(clock), .reset(reset), .bus(bus),
      .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr),
      .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
      .link_we(link_we), .link_addr(link_addr), .link_data(link_data),
      .illegal(illegal)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Register file with one-cycle read latency.
   logic [31:0] rf_mem [32];
   always @(posedge clock) begin
      rf_rs_data <= rf_mem[rf_rs_addr];
      rf_rt_data <= rf_mem[rf_rt_addr];
   end

   typedef struct {
      bit          busy, psrc, link, ill, exv, rfv;
      logic [31:0] tgt, ldata, exa, eximm;
      logic [1:0]  exop;
      logic [4:0]  exdst, rs, rt;
   } exp_t;

   exp_t exp_q [DEPTH];
   int   squash_m = 0;
   int   ex_ready_from = 0;
   int   last_accept = 0;
   int   checks = 0;
   int   errors = 0;
   bit   checks_on = 0;

   int          psrc_count = 0, link_count = 0, ill_count = 0;
   int          last_psrc_cyc = 0, last_link_cyc = 0, ex_run = 0, last_ex_len = 0;
   logic [31:0] last_tgt = '0, last_ldata = '0, last_exa = '0, last_eximm = '0;
   logic [4:0]  last_laddr = '0, last_exdst = '0;
   logic [1:0]  last_exop = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
      end
   endtask

   function automatic exp_t blank();
      exp_t e;
      e = '{default: '0};
      return e;
   endfunction

   // Outcome of one accepted instruction, written onto the expected timeline from edge n.
   task automatic model_accept(input int n, input logic [31:0] w, input logic [31:0] pc);
      int          a, b, kind, r;
      bit          is_jal;
      logic [31:0] tgt, sext;
      a      = $signed(rf_mem[w[25:21]]);
      b      = $signed(rf_mem[w[20:16]]);
      sext   = {{16{w[15]}}, w[15:0]};
      tgt    = pc + sext;
      is_jal = 0;
      kind   = 0;
      case (w[31:26])
         6'h08: kind = (a == b) ? 1 : 0;
         6'h09: kind = (a != b) ? 1 : 0;
         6'h0A: kind = (a >  b) ? 1 : 0;
         6'h0B: kind = (a >= b) ? 1 : 0;
         6'h0C: kind = (a <  b) ? 1 : 0;
         6'h0D: kind = (a <= b) ? 1 : 0;
         6'h0E: begin kind = 1; tgt = {pc[31:26], w[25:0]}; end
         6'h11: begin kind = 1; is_jal = 1; tgt = {pc[31:26], w[25:0]}; end
         6'h0F, 6'h10, 6'h12: kind = 2;
         6'h00: kind = 0;
         default: kind = 3;
      endcase
      for (int c = n; c <= n + 1; c++) begin
         exp_q[c].busy = 1;
         exp_q[c].rfv  = 1;
         exp_q[c].rs   = w[25:21];
         exp_q[c].rt   = w[20:16];
      end
      if (kind == 1) begin
         exp_q[n+2].busy = 1;
         exp_q[n+2].psrc = 1;
         exp_q[n+2].tgt  = tgt;
         if (is_jal) begin
            exp_q[n+2].link  = 1;
            exp_q[n+2].ldata = pc + 1;
         end
         squash_m = SQ;
      end else if (kind == 2) begin
         r = (ex_ready_from > n + 2) ? ex_ready_from : n + 2;
         for (int c = n + 2; c <= r; c++) begin
            exp_q[c].busy  = 1;
            exp_q[c].exv   = 1;
            exp_q[c].exop  = (w[31:26] == 6'h0F) ? 2'd0 : (w[31:26] == 6'h10) ? 2'd1 : 2'd2;
            exp_q[c].exa   = rf_mem[w[25:21]];
            exp_q[c].eximm = sext;
            exp_q[c].exdst = w[20:16];
         end
      end else if (kind == 3) begin
         exp_q[n+2].ill = 1;
      end
   endtask

   task automatic drive(input bit v, input logic [31:0] w, input logic [31:0] pc);
      if (cyc > DEPTH - 100) begin
         $display("FAIL timeline overflow at cycle %0d", cyc);
         $fatal(1, "timeline overflow");
      end
      bus.instr_valid = v;
      bus.instr       = w;
      bus.instr_pc    = pc;
      bus.ex_ready    = (cyc >= ex_ready_from);
      if (v && !exp_q[cyc].busy) begin
         if (squash_m > 0) squash_m--;
         else if (w != 32'd0) begin
            last_accept = cyc + 1;
            model_accept(cyc + 1, w, pc);
         end
      end
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 32'd0, 32'd0);
   endtask

   // wait_cycles < 0 keeps ex_ready high throughout.
   task automatic issue(input logic [31:0] w, input logic [31:0] pc, input int wait_cycles);
      int guard = 0;
      while (exp_q[cyc].busy && guard < 50) begin
         idle(1);
         guard++;
      end
      if (guard >= 50) begin
         errors++;
         $display("FAIL issue_wait at cycle %0d: got busy, expected idle", cyc);
      end
      ex_ready_from = (wait_cycles < 0) ? 0 : cyc + 3 + wait_cycles;
      drive(1, w, pc);
      bus.instr_valid = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      bus.instr_valid = 0;
      for (int c = cyc + 1; c < cyc + 60; c++) exp_q[c] = blank();
      squash_m = 0;
      @(negedge clock);
      reset = 0;
   endtask

   always @(negedge clock) begin : cmp
      exp_t e;
      if (checks_on) begin
         e = exp_q[cyc];
         chk("instr_ready", 32'(bus.instr_ready), 32'(!e.busy));
         chk("pc_source",   32'(bus.pc_source),   32'(e.psrc));
         chk("link_we",     32'(link_we),         32'(e.link));
         chk("illegal",     32'(illegal),         32'(e.ill));
         chk("ex_valid",    32'(bus.ex_valid),    32'(e.exv));
         if (e.psrc) chk("branch_target", bus.branch_target, e.tgt);
         if (e.link) begin
            chk("link_addr", 32'(link_addr), 32'd31);
            chk("link_data", link_data, e.ldata);
         end
         if (e.exv) begin
            chk("ex_op",  32'(bus.ex_op),  32'(e.exop));
            chk("ex_a",   bus.ex_a,        e.exa);
            chk("ex_imm", bus.ex_imm,      e.eximm);
            chk("ex_dst", 32'(bus.ex_dst), 32'(e.exdst));
         end
         if (e.rfv) begin
            chk("rf_rs_addr", 32'(rf_rs_addr), 32'(e.rs));
            chk("rf_rt_addr", 32'(rf_rt_addr), 32'(e.rt));
         end
      end
      if (bus.pc_source === 1'b1) begin
         psrc_count++; last_psrc_cyc = cyc; last_tgt = bus.branch_target;
      end
      if (link_we === 1'b1) begin
         link_count++; last_link_cyc = cyc; last_ldata = link_data; last_laddr = link_addr;
      end
      if (illegal === 1'b1) ill_count++;
      if (bus.ex_valid === 1'b1) begin
         ex_run++; last_exop = bus.ex_op; last_exa = bus.ex_a;
         last_eximm = bus.ex_imm; last_exdst = bus.ex_dst;
      end else if (ex_run > 0) begin
         last_ex_len = ex_run; ex_run = 0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, p0, i0, l0;
      for (int i = 0; i < DEPTH; i++) exp_q[i] = blank();
      for (int i = 0; i < 32; i++) rf_mem[i] = 32'(i * 3);
      rf_mem[0] = 32'd5;  rf_mem[1] = 32'd5;  rf_mem[2] = 32'hFFFF_FFFF;
      rf_mem[3] = 32'd3;  rf_mem[4] = 32'd10; rf_mem[5] = 32'd20; rf_mem[8] = 32'd7;
      bus.instr_valid = 0; bus.instr = '0; bus.instr_pc = '0; bus.ex_ready = 0;

      repeat (2) @(negedge clock);
      checks_on = 1;
      chk("reset_instr_ready", 32'(bus.instr_ready), 32'd1);
      chk("reset_pc_source",   32'(bus.pc_source),   32'd0);
      chk("reset_ex_valid",    32'(bus.ex_valid),    32'd0);
      chk("reset_link_we",     32'(link_we),         32'd0);
      chk("reset_branch_tgt",  bus.branch_target,    32'd0);
      reset = 0;
      idle(2);

      // 1: beq r0,r1,+1 at 0x10, then a wrong-path illegal word that must be squashed.
      issue({6'h08, 5'd0, 5'd1, 16'd1}, 32'h10, -1);
      a0 = last_accept;
      idle(4);
      chk("t1_target",  last_tgt, 32'h11);
      chk("t1_latency", 32'(last_psrc_cyc - a0), 32'd2);
      chk("t1_pulses",  32'(psrc_count), 32'd1);
      i0 = ill_count;
      issue(32'hFC00_0000, 32'h11, -1);
      idle(4);
      chk("t1_squashed", 32'(ill_count), 32'(i0));

      // 2: signed compares.
      p0 = psrc_count;
      issue({6'h0A, 5'd2, 5'd3, 16'd5}, 32'h40, -1);
      idle(4);
      chk("t2_bgt_not_taken", 32'(psrc_count), 32'(p0));
      issue({6'h0C, 5'd2, 5'd3, 16'hFFFC}, 32'h100, -1);
      idle(4);
      chk("t2_blt_target", last_tgt, 32'hFC);
      issue(32'd0, 32'd0, -1);
      issue({6'h0B, 5'd4, 5'd5, 16'd7}, 32'h180, -1);
      issue({6'h0D, 5'd4, 5'd5, 16'h10}, 32'h200, -1);
      idle(4);
      chk("t2_ble_target", last_tgt, 32'h210);
      issue(32'd0, 32'd0, -1);
      p0 = psrc_count;
      issue({6'h09, 5'd0, 5'd1, 16'd3}, 32'h220, -1);
      issue({6'h08, 5'd4, 5'd5, 16'd3}, 32'h224, -1);
      idle(4);
      chk("t2_bne_beq_not_taken", 32'(psrc_count), 32'(p0));

      // 3: jal 9 at 0x20, squash, then j.
      l0 = link_count;
      issue({6'h11, 26'd9}, 32'h20, -1);
      idle(4);
      chk("t3_link_count", 32'(link_count), 32'(l0 + 1));
      chk("t3_link_addr",  32'(last_laddr), 32'd31);
      chk("t3_link_data",  last_ldata, 32'h21);
      chk("t3_target",     last_tgt, 32'h9);
      chk("t3_link_with_redirect", 32'(last_link_cyc), 32'(last_psrc_cyc));
      i0 = ill_count;
      issue(32'hFC00_0001, 32'h21, -1);
      idle(4);
      chk("t3_squashed", 32'(ill_count), 32'(i0));
      issue({6'h0E, 26'h123}, 32'h0400_0010, -1);
      idle(4);
      chk("t3_j_target", last_tgt, 32'h0400_0123);
      issue(32'd0, 32'd0, -1);

      // 4: execute handshake with back-pressure.
      issue({6'h0F, 5'd8, 5'd9, 16'd8}, 32'h60, 4);
      idle(9);
      chk("t4_ex_len", 32'(last_ex_len), 32'd5);
      chk("t4_ex_op",  32'(last_exop),   32'd0);
      chk("t4_ex_imm", last_eximm,       32'd8);
      chk("t4_ex_a",   last_exa,         32'd7);
      chk("t4_ex_dst", 32'(last_exdst),  32'd9);
      issue({6'h10, 5'd4, 5'd6, 16'hFFF0}, 32'h64, -1);
      idle(5);
      chk("t4_divi_len", 32'(last_ex_len), 32'd1);
      chk("t4_divi_imm", last_eximm,       32'hFFFF_FFF0);
      chk("t4_divi_op",  32'(last_exop),   32'd1);
      issue({6'h12, 5'd5, 5'd7, 16'd3}, 32'h68, 2);
      idle(7);
      chk("t4_sra_len", 32'(last_ex_len), 32'd3);
      chk("t4_sra_op",  32'(last_exop),   32'd2);
      chk("t4_sra_a",   last_exa,         32'd20);

      // 5: illegal opcode, then a NOP stream.
      i0 = ill_count;
      issue({6'h3F, 26'h155}, 32'h300, -1);
      idle(4);
      chk("t5_illegal", 32'(ill_count), 32'(i0 + 1));
      p0 = psrc_count; i0 = ill_count;
      repeat (6) drive(1, 32'd0, 32'h304);
      bus.instr_valid = 0;
      chk("t5_nop_ready",   32'(bus.instr_ready), 32'd1);
      chk("t5_nop_no_psrc", 32'(psrc_count), 32'(p0));
      chk("t5_nop_no_ill",  32'(ill_count),  32'(i0));

      // 6: reset during ISSUE, then during REDIRECT.
      issue({6'h0F, 5'd8, 5'd9, 16'd1}, 32'h400, 10);
      idle(3);
      do_reset();
      chk("t6_issue_ex_valid", 32'(bus.ex_valid),    32'd0);
      chk("t6_issue_ready",    32'(bus.instr_ready), 32'd1);
      idle(2);
      issue({6'h08, 5'd0, 5'd1, 16'd2}, 32'h50, -1);
      idle(2);
      do_reset();
      chk("t6_redir_psrc",  32'(bus.pc_source),   32'd0);
      chk("t6_redir_ready", 32'(bus.instr_ready), 32'd1);
      i0 = ill_count;
      issue({6'h3F, 26'd0}, 32'h53, -1);
      idle(4);
      chk("t6_no_squash", 32'(ill_count), 32'(i0 + 1));

      idle(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
